// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - PS/2 protocol constants, FSM states and scancode-to-MC-10 key table.
package ps2_key_pkg;

    localparam logic [7:0] NO_KEY = 8'hFF;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERRF   = 8'hFF;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} frame_state_e;
    typedef enum logic [2:0] {P_IDLE, P_E0, P_F0, P_E0F0, P_SKIP} proto_state_e;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
               (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERRF);
    endfunction

    function automatic logic [7:0] mc10_key(input logic [2:0] col, input logic [2:0] row);
        return {1'b0, col, 1'b0, row};
    endfunction

    // Index is {extended, scancode}; MC-10 matrix rows 0-6, columns 0-7.
    function automatic logic [7:0] map_entry(input logic [8:0] idx);
        case (idx)
            9'h01C: return mc10_key(3'd1, 3'd0); // A
            9'h032: return mc10_key(3'd2, 3'd0); // B
            9'h021: return mc10_key(3'd3, 3'd0); // C
            9'h023: return mc10_key(3'd4, 3'd0); // D
            9'h024: return mc10_key(3'd5, 3'd0); // E
            9'h02B: return mc10_key(3'd6, 3'd0); // F
            9'h034: return mc10_key(3'd7, 3'd0); // G
            9'h033: return mc10_key(3'd0, 3'd1); // H
            9'h043: return mc10_key(3'd1, 3'd1); // I
            9'h03B: return mc10_key(3'd2, 3'd1); // J
            9'h042: return mc10_key(3'd3, 3'd1); // K
            9'h04B: return mc10_key(3'd4, 3'd1); // L
            9'h03A: return mc10_key(3'd5, 3'd1); // M
            9'h031: return mc10_key(3'd6, 3'd1); // N
            9'h044: return mc10_key(3'd7, 3'd1); // O
            9'h04D: return mc10_key(3'd0, 3'd2); // P
            9'h015: return mc10_key(3'd1, 3'd2); // Q
            9'h02D: return mc10_key(3'd2, 3'd2); // R
            9'h01B: return mc10_key(3'd3, 3'd2); // S
            9'h02C: return mc10_key(3'd4, 3'd2); // T
            9'h03C: return mc10_key(3'd5, 3'd2); // U
            9'h02A: return mc10_key(3'd6, 3'd2); // V
            9'h01D: return mc10_key(3'd7, 3'd2); // W
            9'h022: return mc10_key(3'd0, 3'd3); // X
            9'h035: return mc10_key(3'd1, 3'd3); // Y
            9'h01A: return mc10_key(3'd2, 3'd3); // Z
            9'h05A: return mc10_key(3'd6, 3'd3); // ENTER
            9'h15A: return mc10_key(3'd6, 3'd3); // keypad ENTER
            9'h029: return mc10_key(3'd7, 3'd3); // SPACE
            9'h045: return mc10_key(3'd0, 3'd4); // 0
            9'h016: return mc10_key(3'd1, 3'd4); // 1
            9'h01E: return mc10_key(3'd2, 3'd4); // 2
            9'h026: return mc10_key(3'd3, 3'd4); // 3
            9'h025: return mc10_key(3'd4, 3'd4); // 4
            9'h02E: return mc10_key(3'd5, 3'd4); // 5
            9'h036: return mc10_key(3'd6, 3'd4); // 6
            9'h03D: return mc10_key(3'd7, 3'd4); // 7
            9'h03E: return mc10_key(3'd0, 3'd5); // 8
            9'h046: return mc10_key(3'd1, 3'd5); // 9
            9'h04C: return mc10_key(3'd3, 3'd5); // ;
            9'h041: return mc10_key(3'd4, 3'd5); // ,
            9'h04E: return mc10_key(3'd5, 3'd5); // -
            9'h049: return mc10_key(3'd6, 3'd5); // .
            9'h04A: return mc10_key(3'd7, 3'd5); // /
            9'h014: return mc10_key(3'd0, 3'd6); // CTRL
            9'h076: return mc10_key(3'd2, 3'd6); // ESC as BREAK
            9'h012: return mc10_key(3'd7, 3'd6); // SHIFT
            9'h059: return mc10_key(3'd7, 3'd6); // right SHIFT
            default: return NO_KEY;
        endcase
    endfunction

    function automatic logic [511:0][7:0] build_table();
        logic [511:0][7:0] t;
        for (int i = 0; i < 512; i++) begin
            t[i] = map_entry(9'(i));
        end
        return t;
    endfunction

    localparam logic [511:0][7:0] SCANCODE_TABLE = build_table();

endpackage

// File: rtl/scancode_rom.sv
// rtl/scancode_rom.sv - Combinational {ext, scancode} to MC-10 key_code lookup.
module scancode_rom
    import ps2_key_pkg::*;
(
    input  logic [8:0] index,
    output logic [7:0] key_code
);

    always_comb begin
        key_code = SCANCODE_TABLE[index];
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver, make/break protocol decoder and held-key register.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_strobe,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    frame_state_e  fstate_q, fstate_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    proto_state_e  pstate_q, pstate_d;
    logic [2:0]    skip_q, skip_d;
    logic [7:0]    key_q, key_d;
    logic          strobe_q, strobe_d;
    logic          ext;
    logic          brk;
    logic [7:0]    rom_key;

    always_comb begin
        clk_s1_d  = ps2_clk;
        clk_s2_d  = clk_s1_q;
        data_s1_d = ps2_data;
        data_s2_d = data_s1_q;
    end

    // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FILT_MAX) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q && !filt_d;

    always_comb begin
        fstate_d     = fstate_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = '0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            case (fstate_q)
                IDLE: begin
                    if (!data_s2_q) begin
                        fstate_d  = SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        fstate_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_s2_q;
                    fstate_d = STOP;
                end
                STOP: begin
                    if (data_s2_q && (^{shift_q, parity_q})) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    fstate_d = IDLE;
                end
                default: fstate_d = IDLE;
            endcase
        end else if (fstate_q != IDLE) begin
            if (tmo_q == TMO_MAX) begin
                fstate_d  = IDLE;
                bit_cnt_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign ext = (pstate_q == P_E0) || (pstate_q == P_E0F0);
    assign brk = (pstate_q == P_F0) || (pstate_q == P_E0F0);

    scancode_rom u_rom (
        .index    ({ext, shift_q}),
        .key_code (rom_key)
    );

    always_comb begin
        pstate_d = pstate_q;
        skip_d   = skip_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        if (frame_err_q) begin
            pstate_d = P_IDLE;
        end else if (byte_valid_q) begin
            if (pstate_q == P_SKIP) begin
                skip_d = skip_q - 1'b1;
                if (skip_q == 3'd1) begin
                    pstate_d = P_IDLE;
                end
            end else if (shift_q == SC_E1) begin
                skip_d   = 3'd7;
                pstate_d = P_SKIP;
            end else if (shift_q == SC_E0) begin
                pstate_d = P_E0;
            end else if (shift_q == SC_F0) begin
                if (pstate_q == P_IDLE) begin
                    pstate_d = P_F0;
                end else if (pstate_q == P_E0) begin
                    pstate_d = P_E0F0;
                end
            end else begin
                pstate_d = P_IDLE;
                if (!is_ignored(shift_q) && rom_key != NO_KEY) begin
                    if (!brk) begin
                        key_d    = rom_key;
                        strobe_d = 1'b1;
                    end else if (rom_key == key_q) begin
                        key_d = NO_KEY;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            fstate_q     <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pstate_q     <= P_IDLE;
            skip_q       <= '0;
            key_q        <= NO_KEY;
            strobe_q     <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            fstate_q     <= fstate_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            pstate_q     <= pstate_d;
            skip_q       <= skip_d;
            key_q        <= key_d;
            strobe_q     <= strobe_d;
        end
    end

    assign key_code   = key_q;
    assign key_strobe = strobe_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - Directed self-checking bench for ps2_key_decoder.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_strobe;
    logic       frame_err;

    int checks = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int s0;
    int e0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(50000)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always @(negedge clk) begin
        if (key_strobe) strobe_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clocks the first nbits of start, data LSB first, odd parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b0, 11);
    endtask

    initial begin
        wait_clks(3);
        check("reset_key_code", 32'(key_code), 32'hFF);
        check("reset_strobe", 32'(key_strobe), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_clks(5);

        s0 = strobe_cnt;
        send_byte(8'h1C);
        check("make_A_key", 32'(key_code), 32'h10);
        check("make_A_strobes", 32'(strobe_cnt - s0), 32'd1);
        s0 = strobe_cnt;
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("break_A_key", 32'(key_code), 32'hFF);
        check("break_A_strobes", 32'(strobe_cnt - s0), 32'd0);

        s0 = strobe_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        check("repeat_A_key", 32'(key_code), 32'h10);
        check("repeat_A_strobes", 32'(strobe_cnt - s0), 32'd2);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("repeat_release", 32'(key_code), 32'hFF);

        send_byte(8'h1C);
        check("two_key_A", 32'(key_code), 32'h10);
        send_byte(8'h1A);
        check("two_key_Z", 32'(key_code), 32'h23);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("stale_break_ignored", 32'(key_code), 32'h23);
        send_byte(8'hF0);
        send_byte(8'h1A);
        check("break_Z", 32'(key_code), 32'hFF);

        e0 = err_cnt;
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b1, 11);
        check("parity_err_pulse", 32'(err_cnt - e0), 32'd1);
        check("parity_err_key", 32'(key_code), 32'hFF);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("after_err_break_key", 32'(key_code), 32'hFF);
        check("after_err_strobes", 32'(strobe_cnt - s0), 32'd0);

        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 5);
        wait_clks(50100);
        send_byte(8'h1C);
        check("timeout_recover_key", 32'(key_code), 32'h10);
        check("timeout_no_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("timeout_release", 32'(key_code), 32'hFF);

        s0 = strobe_cnt;
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        check("pause_key", 32'(key_code), 32'hFF);
        check("pause_strobes", 32'(strobe_cnt - s0), 32'd0);

        e0 = err_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_clks(7);
        ps2_clk = 1'b1;
        wait_clks(30);
        ps2_data = 1'b1;
        wait_clks(10);
        send_byte(8'h1C);
        check("glitch_ignored_key", 32'(key_code), 32'h10);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("glitch_release", 32'(key_code), 32'hFF);
        send_frame(8'h1C, 1'b0, 10);
        reset = 1'b1;
        wait_clks(3);
        check("midframe_reset_key", 32'(key_code), 32'hFF);
        reset = 1'b0;
        wait_clks(5);
        check("after_reset_key", 32'(key_code), 32'hFF);
        send_byte(8'h1C);
        check("after_reset_make", 32'(key_code), 32'h10);
        check("glitch_no_err", 32'(err_cnt - e0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the keyboard matrix emulator. Receives raw PS/2 keyboard frames and decodes the make/break scancode protocol.
- Translates each scancode into the 8-bit MC-10 matrix key_code: column in bits 6:4, row in bits 2:0, bits 7 and 3 zero.
- Holds the key_code for as long as the key is down, so the matrix stage can answer row scans combinationally.

Parameters:
- FILTER_LEN, 8: number of consecutive equal synchronized samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: count of clk cycles with no filtered falling edge mid-frame after which the partial frame is discarded.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from the pad; asynchronous
- ps2_data  input  1  raw PS/2 data from the pad; asynchronous
- key_code  output  8  current held key in matrix encoding; NO_KEY when no key is held
- key_strobe  output  1  one-cycle pulse whenever a make code for a mapped key is accepted
- frame_err  output  1  one-cycle pulse on a parity or stop-bit error

Behaviour:
- Reset (asynchronous, active-high):
  - key_code=NO_KEY (8'hFF; row 7 is unused by the MC-10 matrix, so no row scan matches it).
  - key_strobe=0, frame_err=0.
  - Frame FSM to IDLE, protocol FSM to P_IDLE, bit counter=0, timeout counter=0.
  - Reset asserted mid-frame discards the partial byte.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - ps2_clk is then filtered: its filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered ps2_clk produces a one-cycle fall pulse; data is sampled on that pulse.
- Frame FSM states: IDLE, SHIFT, PARITY, STOP.
  - IDLE: on fall with data=0 go to SHIFT; on fall with data=1 ignore the pulse and stay in IDLE.
  - SHIFT: 8 data bits, LSB first, into the shift register; after the 8th bit go to PARITY.
  - PARITY: capture the bit; odd parity over data plus parity bit is required; go to STOP.
  - STOP: sample the stop bit. Stop=1 with parity OK gives byte_valid for 1 cycle. Otherwise pulse frame_err and reset the protocol FSM to P_IDLE. Either way, return to IDLE.
  - Timeout: in any state other than IDLE, the timeout counter increments each cycle and clears on each fall pulse. Reaching TIMEOUT_CYCLES returns the FSM to IDLE silently, with no frame_err.
- Protocol FSM states: P_IDLE, P_E0, P_F0, P_E0F0, P_SKIP. It acts only on byte_valid.
  - Byte E0: P_IDLE goes to P_E0.
  - Byte F0: P_IDLE goes to P_F0; P_E0 goes to P_E0F0.
  - Byte E1: load skip counter=7 and go to P_SKIP. P_SKIP consumes 7 bytes with no output, then returns to P_IDLE.
  - Bytes AA, FA, EE, FE, 00, FF: ignored, and the FSM returns to P_IDLE.
  - Any other byte is a make code in P_IDLE/P_E0 and a break code in P_F0/P_E0F0. Its extended flag is 1 in P_E0 and P_E0F0. The FSM then returns to P_IDLE.
- Lookup:
  - Index is {ext, byte} (9 bits), through scancode_rom.
  - Unmapped entries return NO_KEY.
  - A make or break whose lookup returns NO_KEY is ignored.
- Make (mapped):
  - key_code <= mapped value and key_strobe pulses.
  - An autorepeat make of the same key still pulses key_strobe.
  - A new key replaces the old one; only one key is held at a time.
- Break (mapped):
  - If the mapped value equals key_code, key_code <= NO_KEY.
  - A break of a key that is not held is ignored, with no output change.
- Latency: key_code and key_strobe update on the 2nd clk edge after the fall pulse that samples the stop bit (edge 1: byte_valid; edge 2: outputs).
- Simultaneous events: byte_valid and the timeout cannot coincide, because the fall pulse clears the timeout counter; if they did, the fall pulse takes priority.

Decomposition:
- Package ps2_key_pkg:
  - NO_KEY=8'hFF.
  - Prefix constants E0, F0, E1.
  - Ignore-list constants.
  - Frame FSM and protocol FSM state enums.
  - The 512-entry scancode-to-key_code table constant.
- Sub-module scancode_rom: combinational, 9-bit index in, 8-bit key_code out, reading the package table.
- Everything else stays in ps2_key_decoder.

Test Plan:
- Frame 1C (A): key_code 8'h10 and 1 key_strobe pulse. Then F0,1C: key_code 8'hFF with no strobe.
- 1C, then 1A (Z): key_code 8'h10 then 8'h23. Then F0,1C: key_code stays 8'h23. Then F0,1A: key_code 8'hFF.
- 1C frame with a flipped parity bit: frame_err pulses once and key_code stays 8'hFF. A following valid F0 then 1C: the F0 is honoured and key_code stays 8'hFF.
- Stop clocking after 4 data bits for more than TIMEOUT_CYCLES, then send a full 1C frame: key_code 8'h10 and no frame_err.
- Send E1,14,77,E1,F0,14,F0,77: key_code stays 8'hFF and key_strobe never pulses.
- Glitch ps2_clk low for FILTER_LEN-1 cycles while idle, then assert reset while 1C is pending at the stop bit: no bit is captured from the glitch. After reset, key_code=8'hFF and a following 1C frame yields 8'h10.
